// File: rtl/sram_sp_ctrl.sv
// sram_sp_ctrl: round-robin write/read arbiter in front of a single-port SRAM.
// Define SRAM_CLEAR_EN to zero-fill the whole array after reset.
module sram_sp_ctrl #(
  parameter int depth = 8,
  parameter int width = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [$clog2(depth)-1:0] wr_add,
  input  logic [width-1:0]         wr_data,
  input  logic                     rq_valid,
  output logic                     rq_ready,
  input  logic [$clog2(depth)-1:0] rq_add,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [width-1:0]         rd_data,
  output logic                     busy,
  output logic [$clog2(depth)-1:0] mem_add,
  output logic [width-1:0]         mem_data_in,
  output logic                     mem_we,
  output logic                     mem_re,
  input  logic [width-1:0]         mem_data_out
);

  localparam int AW = $clog2(depth);

  logic slot_free;
  logic w_el;
  logic r_el;
  logic gnt_w;
  logic gnt_r;
  logic prio_w;

`ifdef SRAM_CLEAR_EN
  typedef enum logic {CLEAR, IDLE} state_t;

  state_t        state;
  state_t        state_n;
  logic [AW-1:0] clr_add;
  logic [AW-1:0] clr_add_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_add <= '0;
    end else begin
      state   <= state_n;
      clr_add <= clr_add_n;
    end
  end

  // Stop on the last real word so odd depths never wrap.
  always_comb begin
    state_n   = state;
    clr_add_n = clr_add;
    unique case (state)
      CLEAR: begin
        if (clr_add == AW'(depth - 1))
          state_n = IDLE;
        else
          clr_add_n = clr_add + AW'(1);
      end
      default: ;
    endcase
  end

  assign busy = (state == CLEAR);
`else
  assign busy = 1'b0;
`endif

  // Gating with rst_n keeps every grant and strobe quiet while in reset.
  assign slot_free = !rd_valid || rd_ready;
  assign w_el  = rst_n && !busy && wr_valid;
  assign r_el  = rst_n && !busy && rq_valid && slot_free;
  assign gnt_w = w_el && (!r_el || prio_w);
  assign gnt_r = r_el && (!w_el || !prio_w);

  assign wr_ready = gnt_w;
  assign rq_ready = gnt_r;

  always_comb begin
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_add     = '0;
    mem_data_in = '0;
    unique case (1'b1)
`ifdef SRAM_CLEAR_EN
      (busy && rst_n): begin
        mem_we  = 1'b1;
        mem_add = clr_add;
      end
`endif
      gnt_w: begin
        mem_we      = 1'b1;
        mem_add     = wr_add;
        mem_data_in = wr_data;
      end
      gnt_r: begin
        mem_re  = 1'b1;
        mem_add = rq_add;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_w   <= 1'b1;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (gnt_w)
        prio_w <= 1'b0;
      else if (gnt_r)
        prio_w <= 1'b1;
      if (gnt_r) begin
        rd_valid <= 1'b1;
        rd_data  <= mem_data_out;
      end else if (rd_ready) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_sp_ctrl.sv
// tb_sram_sp_ctrl: scoreboard bench with a behavioural SRAM and arbiter model.
// Works with and without SRAM_CLEAR_EN.
module tb_sram_sp_ctrl;

  localparam int D  = 8;
  localparam int W  = 4;
  localparam int AW = $clog2(D);
`ifdef SRAM_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_add = '0;
  logic [W-1:0]  wr_data = '0;
  logic          rq_valid = 1'b0;
  logic          rq_ready;
  logic [AW-1:0] rq_add = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b1;
  logic [W-1:0]  rd_data;
  logic          busy;
  logic [AW-1:0] mem_add;
  logic [W-1:0]  mem_data_in;
  logic          mem_we;
  logic          mem_re;
  logic [W-1:0]  mem_data_out;

  sram_sp_ctrl #(.depth(D), .width(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_add(wr_add), .wr_data(wr_data),
    .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_add(rq_add),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .mem_add(mem_add), .mem_data_in(mem_data_in),
    .mem_we(mem_we), .mem_re(mem_re), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  logic [W-1:0] sram [D];
  always_ff @(posedge clk)
    if (mem_we) sram[mem_add] <= mem_data_in;
  assign mem_data_out = mem_re ? sram[mem_add] : 'x;

  int checks = 0;
  int failures = 0;

  logic [W-1:0]  ref_mem [D];
  logic [W-1:0]  exp_q [$];
  logic          rv_m, prio_m, busy_m;
  logic [AW-1:0] clr_m;
  logic          last_gw, last_wrr, last_rqr, last_busy;
  logic [W-1:0]  last_rdd;
  int            cyc, last_cyc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic ew, er, gw, gr;
    @(negedge clk);
    ew = wr_valid && !busy_m;
    er = rq_valid && !busy_m && (!rv_m || rd_ready);
    gw = ew && (!er || prio_m);
    gr = er && (!ew || !prio_m);
    chk("grant", {wr_ready, rq_ready}, {gw, gr});
    chk("busy", busy, busy_m);
    chk("we_re", {mem_we, mem_re}, {gw || busy_m, gr});
    if (busy_m)
      chk("clr_drive", {mem_add, mem_data_in}, {clr_m, W'(0)});
    else if (gw)
      chk("wr_drive", {mem_add, mem_data_in}, {wr_add, wr_data});
    else if (gr)
      chk("rd_add", mem_add, rq_add);
    else
      chk("idle_drive", {mem_add, mem_data_in}, 0);
    chk("rd_valid", rd_valid, rv_m);
    if (rv_m) begin
      if (exp_q.size() == 0)
        chk("sb_size", exp_q.size(), 1);
      else begin
        chk("rd_data", rd_data, exp_q[0]);
        if (rd_ready) void'(exp_q.pop_front());
      end
    end
    last_wrr = wr_ready;
    last_rqr = rq_ready;
    last_busy = busy;
    last_rdd = rd_data;
    if (busy_m) begin
      ref_mem[clr_m] = '0;
      if (clr_m == AW'(D - 1)) busy_m = 1'b0;
      else clr_m = clr_m + 1'b1;
    end
    if (gw) ref_mem[wr_add] = wr_data;
    if (gr) exp_q.push_back(ref_mem[rq_add]);
    rv_m = gr ? 1'b1 : (rd_ready ? 1'b0 : rv_m);
    if (gw) prio_m = 1'b0;
    else if (gr) prio_m = 1'b1;
    last_gw = gw;
    last_cyc = cyc;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    int n = 0;
    wr_valid = 1'b1;
    wr_add = a;
    wr_data = d;
    do begin
      tick();
      n++;
    end while (!last_wrr && n < 40);
    chk("wr_accept", last_wrr, 1);
    wr_valid = 1'b0;
  endtask

  task automatic rq(input logic [AW-1:0] a);
    int n = 0;
    rq_valid = 1'b1;
    rq_add = a;
    do begin
      tick();
      n++;
    end while (!last_rqr && n < 40);
    chk("rq_accept", last_rqr, 1);
    rq_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_ready", {wr_ready, rq_ready}, 0);
    chk("rst_mem", {mem_we, mem_re, mem_add, mem_data_in}, 0);
    chk("rst_busy", busy, CLR);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rv_m = 1'b0;
    prio_m = 1'b1;
    busy_m = CLR;
    clr_m = '0;
    exp_q.delete();
    cyc = 0;
  endtask

  initial begin
    int n;
    logic [3:0] pat;
    for (int i = 0; i < D; i++) ref_mem[i] = '0;
    #3;
    wr_valid = 1'b1;
    rq_valid = 1'b1;
    do_reset();
    wr_valid = 1'b0;
    rq_valid = 1'b0;

    wr(3'd7, 4'h9);
    chk("first_accept_cycle", last_cyc, CLR ? D : 0);
    rq(3'd7);
    if (CLR) rq(3'd5);
    wr(3'd3, 4'hA);
    rq(3'd3);
    repeat (2) tick();

    wr(3'd1, 4'h5);
    wr(3'd0, 4'h6);
    wr(3'd2, 4'h3);
    tick();

    rd_ready = 1'b0;
    rq(3'd1);
    wr_valid = 1'b1; wr_add = 3'd1; wr_data = 4'hC;
    rq_valid = 1'b1; rq_add = 3'd0;
    tick();
    chk("bp_wr_ready", last_wrr, 1);
    chk("bp_rq_ready", last_rqr, 0);
    chk("bp_hold", last_rdd, 4'h5);
    wr_valid = 1'b0;
    tick();
    chk("bp_hold2", last_rdd, 4'h5);
    rd_ready = 1'b1;
    tick();
    chk("pop_refill", last_rqr, 1);
    rq_valid = 1'b0;

    pat = '0;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_add = AW'(4 + i); wr_data = W'(8 + i);
      rq_valid = 1'b1; rq_add = AW'(i);
      tick();
      pat = {pat[2:0], last_wrr};
    end
    chk("contention_pat", pat, 4'b1010);
    wr_valid = 1'b0;

    n = 0;
    for (int i = 0; i < 4; i++) begin
      rq_valid = 1'b1; rq_add = AW'(i + 4);
      tick();
      if (last_rqr) n++;
    end
    chk("burst_rate", n, 4);
    rq_valid = 1'b0;
    tick();

    rd_ready = 1'b0;
    rq(3'd3);
    do_reset();
    rd_ready = 1'b1;
    if (CLR) begin
      n = 0;
      while (clr_m != AW'(4) && n < 20) begin
        tick();
        n++;
      end
      do_reset();
    end
    n = 0;
    do begin
      tick();
      if (last_busy) n++;
    end while (last_busy && n < 40);
    chk("busy_cycles", n, CLR ? D : 0);
    rq(CLR ? 3'd5 : 3'd7);
    tick();

    for (int i = 0; i < 300; i++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_add = AW'($urandom_range(0, D - 1));
      wr_data = W'($urandom_range(0, 15));
      rq_valid = 1'($urandom_range(0, 1));
      rq_add = AW'($urandom_range(0, D - 1));
      rd_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    wr_valid = 1'b0;
    rq_valid = 1'b0;
    rd_ready = 1'b1;
    repeat (3) tick();
    chk("sb_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
